// File: rtl/pipe_bp_pkg.sv
// Shared definitions for the IF-stage branch predictor.
// Holds the 2-bit counter encodings, the counter training function and
// width helpers that derive the BTB tag width from the index width.
package pipe_bp_pkg;

  localparam int DEF_IDX_W = 4;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // PC[1:0] is always zero for aligned fetch, so index + tag cover PC[31:2].
  function automatic int tag_w(input int idx_w);
    return 30 - idx_w;
  endfunction

  function automatic int n_entries(input int idx_w);
    return 1 << idx_w;
  endfunction

  // Saturating 2-bit counter step.
  function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'b01;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pipe_if_branch_pred_btb_ram.sv
// Direct-mapped branch target buffer.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   rd_idx, rd_tag             asynchronous lookup (fetch PC)
//   rd_hit, rd_target, rd_ctr  lookup result, pre-update contents
//   wr_en                      write port enable (pipeline advance)
//   wr_idx, wr_tag             entry addressed by the ID-stage PC
//   wr_alloc                   allocate/rewrite entry
//   wr_train                   train counter if the entry hits
//   wr_taken, wr_target        resolved direction and next PC
module btb_ram
  import pipe_bp_pkg::*;
#(
  parameter int         IDX_W   = DEF_IDX_W,
  parameter logic [1:0] RST_CTR = WNT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IDX_W-1:0]          rd_idx,
  input  logic [tag_w(IDX_W)-1:0]   rd_tag,
  output logic                      rd_hit,
  output logic [31:0]               rd_target,
  output logic [1:0]                rd_ctr,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [tag_w(IDX_W)-1:0]   wr_tag,
  input  logic                      wr_alloc,
  input  logic                      wr_train,
  input  logic                      wr_taken,
  input  logic [31:0]               wr_target
);

  localparam int TAG_W = tag_w(IDX_W);
  localparam int N     = n_entries(IDX_W);

  logic              valid_q  [N];
  logic [TAG_W-1:0]  tag_q    [N];
  logic [31:0]       target_q [N];
  logic [1:0]        ctr_q    [N];

  logic wr_hit;

  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_target = target_q[rd_idx];
  assign rd_ctr    = ctr_q[rd_idx];

  // Training only applies to an entry that already belongs to this PC.
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= RST_CTR;
      end
    end else if (wr_en) begin
      if (wr_alloc) begin
        valid_q[wr_idx] <= 1'b1;
        ctr_q[wr_idx]   <= wr_taken ? WT : RST_CTR;
      end else if (wr_train && wr_hit) begin
        ctr_q[wr_idx]   <= sat_next(ctr_q[wr_idx], wr_taken);
      end
    end
  end

  // Tags and targets need no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (!rst && wr_en && wr_alloc) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/pipe_if_branch_pred.sv
// IF-stage branch predictor feeding the IF/ID boundary.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   wpcir              pipeline advance enable (0 = stall)
//   pc                 fetch PC in IF
//   pcd                PC of the instruction in ID (update index/tag)
//   ud_BTB, ud_pdt     allocate entry / train counter for pcd
//   real_taken         resolved direction of the ID instruction
//   real_bjpc          resolved next PC from ID
//   pre_fch_wrong      ID detected a mispredict
//   npc                next fetch PC (combinational)
//   pre_taken          registered prediction entering ID
//   pre_bjpc           registered predicted next PC entering ID
//   if_flush           kill the IF instruction (combinational)
//   miss_cnt           mispredict counter
module pipe_if_branch_pred
  import pipe_bp_pkg::*;
#(
  parameter int         IDX_W   = DEF_IDX_W,
  parameter logic [1:0] RST_CTR = WNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wpcir,
  input  logic [31:0] pc,
  input  logic [31:0] pcd,
  input  logic        ud_BTB,
  input  logic        ud_pdt,
  input  logic        real_taken,
  input  logic [31:0] real_bjpc,
  input  logic        pre_fch_wrong,
  output logic [31:0] npc,
  output logic        pre_taken,
  output logic [31:0] pre_bjpc,
  output logic        if_flush,
  output logic [31:0] miss_cnt
);

  localparam int TAG_W = tag_w(IDX_W);

  logic        f_hit;
  logic [31:0] f_target;
  logic [1:0]  f_ctr;
  logic        f_taken;
  logic [31:0] f_next;

  // Word-aligned fetch: the low two PC bits carry no information.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{pc[1:0], pcd[1:0], f_ctr[0]};

  btb_ram #(
    .IDX_W   (IDX_W),
    .RST_CTR (RST_CTR)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (pc[IDX_W+1:2]),
    .rd_tag    (pc[31:IDX_W+2]),
    .rd_hit    (f_hit),
    .rd_target (f_target),
    .rd_ctr    (f_ctr),
    .wr_en     (wpcir),
    .wr_idx    (pcd[IDX_W+1:2]),
    .wr_tag    (pcd[31:IDX_W+2]),
    .wr_alloc  (ud_BTB),
    .wr_train  (ud_pdt),
    .wr_taken  (real_taken),
    .wr_target (real_bjpc)
  );

  assign f_taken  = f_hit & f_ctr[1];
  assign f_next   = f_taken ? f_target : (pc + 32'd4);
  assign npc      = pre_fch_wrong ? real_bjpc : f_next;
  assign if_flush = pre_fch_wrong & wpcir;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_taken <= 1'b0;
      pre_bjpc  <= 32'd0;
      miss_cnt  <= 32'd0;
    end else if (wpcir) begin
      // A flushed slot becomes a bubble; ID never checks a bubble.
      if (if_flush) begin
        pre_taken <= 1'b0;
        pre_bjpc  <= 32'd0;
      end else begin
        pre_taken <= f_taken;
        pre_bjpc  <= f_next;
      end
      if (pre_fch_wrong) miss_cnt <= miss_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_if_branch_pred.sv
// Directed self-checking bench for pipe_if_branch_pred.
module tb_pipe_if_branch_pred;

  logic        clk = 1'b0;
  logic        rst;
  logic        wpcir;
  logic [31:0] pc;
  logic [31:0] pcd;
  logic        ud_BTB;
  logic        ud_pdt;
  logic        real_taken;
  logic [31:0] real_bjpc;
  logic        pre_fch_wrong;
  logic [31:0] npc;
  logic        pre_taken;
  logic [31:0] pre_bjpc;
  logic        if_flush;
  logic [31:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_if_branch_pred dut (
    .clk           (clk),
    .rst           (rst),
    .wpcir         (wpcir),
    .pc            (pc),
    .pcd           (pcd),
    .ud_BTB        (ud_BTB),
    .ud_pdt        (ud_pdt),
    .real_taken    (real_taken),
    .real_bjpc     (real_bjpc),
    .pre_fch_wrong (pre_fch_wrong),
    .npc           (npc),
    .pre_taken     (pre_taken),
    .pre_bjpc      (pre_bjpc),
    .if_flush      (if_flush),
    .miss_cnt      (miss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ud_BTB        = 1'b0;
    ud_pdt        = 1'b0;
    real_taken    = 1'b0;
    pre_fch_wrong = 1'b0;
    real_bjpc     = 32'd0;
  endtask

  // One training edge on pcd=0x100, then look up pc=0x100.
  task automatic train(input logic tk, input logic [31:0] exp_npc, input string tag);
    pcd = 32'h100; ud_pdt = 1'b1; real_taken = tk; pc = 32'h100;
    step();
    ud_pdt = 1'b0; real_taken = 1'b0;
    #1;
    chk(tag, npc, exp_npc);
  endtask

  initial begin
    rst = 1'b1; wpcir = 1'b1; pc = 32'h0; pcd = 32'h0;
    idle();
    step();
    step();
    rst = 1'b0;
    #1;
    // 1. reset state and miss path
    chk("rst_pre_taken", {31'd0, pre_taken}, 32'd0);
    chk("rst_pre_bjpc", pre_bjpc, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    pc = 32'h40;
    #1;
    chk("miss_npc_40", npc, 32'h44);
    chk("no_flush", {31'd0, if_flush}, 32'd0);

    // 2. allocate 0x100 -> 0x200 taken; no write-through before the edge
    pc = 32'h100; pcd = 32'h100; ud_BTB = 1'b1; real_taken = 1'b1; real_bjpc = 32'h200;
    #1;
    chk("no_write_through", npc, 32'h104);
    step();
    idle();
    #1;
    chk("alloc_npc", npc, 32'h200);
    chk("alloc_edge_pre_bjpc", pre_bjpc, 32'h104);
    step();
    chk("hit_pre_taken", {31'd0, pre_taken}, 32'd1);
    chk("hit_pre_bjpc", pre_bjpc, 32'h200);

    // 3. saturation: 10 ->11 ->11 ->11, then down and back up
    train(1'b1, 32'h200, "t1");
    train(1'b1, 32'h200, "t2");
    train(1'b1, 32'h200, "t3_sat_hi");
    train(1'b0, 32'h200, "nt1_ctr10");
    train(1'b0, 32'h104, "nt2_ctr01");
    train(1'b0, 32'h104, "nt3_ctr00");
    train(1'b0, 32'h104, "nt4_sat_lo");
    train(1'b1, 32'h104, "t_ctr01");
    train(1'b1, 32'h200, "t_ctr10");
    // training a non-hitting pcd must not touch the 0x100 entry
    pcd = 32'h140; ud_pdt = 1'b1; real_taken = 1'b0; pc = 32'h100;
    step();
    idle();
    #1;
    chk("train_miss_ignored", npc, 32'h200);

    // 4. mispredict redirect and flush
    pc = 32'h100; pre_fch_wrong = 1'b1; real_bjpc = 32'h300;
    #1;
    chk("mp_npc", npc, 32'h300);
    chk("mp_flush", {31'd0, if_flush}, 32'd1);
    step();
    idle();
    #1;
    chk("mp_pre_taken", {31'd0, pre_taken}, 32'd0);
    chk("mp_pre_bjpc", pre_bjpc, 32'd0);
    chk("mp_miss_cnt", miss_cnt, 32'd1);

    // 5. stall: nothing updates
    wpcir = 1'b0; pc = 32'h100; pcd = 32'h100;
    ud_BTB = 1'b1; ud_pdt = 1'b1; real_taken = 1'b0; pre_fch_wrong = 1'b1; real_bjpc = 32'h500;
    #1;
    chk("stall_flush", {31'd0, if_flush}, 32'd0);
    chk("stall_npc", npc, 32'h500);
    step();
    chk("stall_pre_taken", {31'd0, pre_taken}, 32'd0);
    chk("stall_pre_bjpc", pre_bjpc, 32'd0);
    chk("stall_miss_cnt", miss_cnt, 32'd1);
    idle();
    wpcir = 1'b1;
    #1;
    chk("stall_table_kept", npc, 32'h200);

    // 6. aliasing and reset with a pending update
    pc = 32'h140;
    #1;
    chk("alias_miss", npc, 32'h144);
    rst = 1'b1; pcd = 32'h100; ud_BTB = 1'b1; real_taken = 1'b1;
    real_bjpc = 32'h200; pre_fch_wrong = 1'b1;
    step();
    rst = 1'b0;
    idle();
    pc = 32'h100;
    #1;
    chk("rst_invalidates", npc, 32'h104);
    chk("rst_drop_miss", miss_cnt, 32'd0);
    chk("rst_drop_pre_bjpc", pre_bjpc, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_if_branch_pred.md
Name: pipe_if_branch_pred

Overview:
IF-stage branch predictor placed directly upstream of the ID stage. It uses a direct-mapped branch target buffer (BTB) with 2-bit saturating counters to predict each fetched PC, selects the next fetch PC, and registers the prediction (pre_taken, pre_bjpc) into the IF/ID boundary for ID to check. It consumes the ID stage's resolution (ud_BTB, ud_pdt, real_bjpc, pre_fch_wrong), redirects fetch on a mispredict, and counts mispredicts.

Parameters:
IDX_W, 4, BTB index width; the BTB has 2^IDX_W entries.
RST_CTR, 2'b01, counter value loaded on reset and on allocate-not-taken.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
wpcir  in  1  pipeline advance enable (0 = stall); gates every state update.
pc  in  32  fetch PC in IF.
pcd  in  32  PC of the instruction in ID; used as the update index and tag.
ud_BTB  in  1  allocate or rewrite the BTB entry for pcd.
ud_pdt  in  1  train the counter for pcd.
real_taken  in  1  resolved direction of the ID instruction.
real_bjpc  in  32  resolved next PC from ID.
pre_fch_wrong  in  1  ID mispredict; the IF instruction is wrong.
npc  out  32  next fetch PC; the datapath PC register loads it when wpcir=1.
pre_taken  out  1  registered prediction for the instruction entering ID.
pre_bjpc  out  32  registered predicted next PC for that instruction.
if_flush  out  1  kill the IF instruction (replace it with a bubble at IF/ID).
miss_cnt  out  32  mispredict counter.

Behaviour:
- BTB entry fields: valid, tag = PC[31:IDX_W+2], target[31:0], ctr[1:0]. Index = PC[IDX_W+1:2].
- Lookup is combinational on pc:
  - hit = valid & tag match.
  - f_taken = hit & ctr[1].
  - f_next = f_taken ? target : pc+4.
  - Reads return pre-update contents. There is no write-through in the cycle of an update.
- npc = pre_fch_wrong ? real_bjpc : f_next.
- if_flush = pre_fch_wrong & wpcir.
- IF/ID prediction registers, updated only when wpcir=1:
  - if_flush=1: pre_taken<=0, pre_bjpc<=0. ID qualifies its check on branch/jump instructions, so a bubble never mispredicts.
  - otherwise: pre_taken<=f_taken, pre_bjpc<=f_next.
  - wpcir=0: both hold.
- Table update, only when wpcir=1, at the index and tag of pcd:
  - ud_BTB: valid<=1, tag<=pcd tag, target<=real_bjpc, ctr<= real_taken ? 2'b10 : RST_CTR.
  - ud_pdt without ud_BTB: applied only if the pcd entry hits. real_taken increments ctr, saturating at 11; otherwise it decrements, saturating at 00.
  - ud_BTB and ud_pdt together: the ud_BTB result wins.
- miss_cnt increments when pre_fch_wrong & wpcir, and wraps from 0xFFFFFFFF to 0.
- Reset:
  - Clears valid in all entries and sets every ctr=RST_CTR. Targets and tags are don't-care.
  - pre_taken=0, pre_bjpc=0, miss_cnt=0.
  - Reset wins over any simultaneous update, flush or stall. Reset during a pending mispredict drops it.
- npc and if_flush are combinational. They are valid during reset but ignored by the datapath.
- Latency: allocate at edge N; pc = pcd predicts at cycle N+1 onward.

Decomposition:
- Package pipe_bp_pkg holds:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - a function sat_next(ctr, taken);
  - tag/index width helpers derived from IDX_W.
- One sub-module, btb_ram: the entry array with one asynchronous read port (pc) and one synchronous write port (pcd). The top holds the npc mux, the IF/ID registers and the counter.

Test Plan:
1. Reset → pre_taken=0, pre_bjpc=0, miss_cnt=0. pc=0x00000040 → npc=0x00000044; every pc misses.
2. Allocate: wpcir=1, pcd=0x00000100, ud_BTB=1, real_taken=1, real_bjpc=0x00000200 → next cycle pc=0x100 gives npc=0x200. After an edge, pre_taken=1 and pre_bjpc=0x200.
3. Saturation:
   - From 2 above, ud_pdt taken x3 → ctr=11 and holds.
   - ud_pdt not-taken x1 → ctr=10, npc=0x200.
   - A second not-taken → ctr=01, npc=0x104.
4. Mispredict: pre_fch_wrong=1, real_bjpc=0x00000300, wpcir=1 → npc=0x300, if_flush=1. After the edge, pre_taken=0, pre_bjpc=0, miss_cnt=1.
5. Stall: wpcir=0 with ud_BTB, ud_pdt and pre_fch_wrong all =1 → if_flush=0. No table change, pre_* hold, miss_cnt holds.
6. Aliasing/reset: with the entry for 0x100 allocated, pc=0x140 (same index, different tag) misses → npc=0x144. Assert rst with an update pending → the entry for 0x100 is invalid afterwards.
